uart_char_packet_rx: RTL and testbench
======================================

# uart_char_packet_rx

Receive-side decoder for the switch-driven character link: deserialises UART frames arriving on the loopback/input pin (JC), reassembles the two-byte character packet (attribute byte + ASCII byte) produced by the send-button path, and presents one decoded character with its colour and language attributes to the text buffer through a valid/ready handshake. Sits between the top-level RX pin and the text-buffer write port.

## Interface
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be ≥ 8
- TIMEOUT_CYCLES, 20*868, maximum idle cycles between header byte and ASCII byte
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- rx  in  1  asynchronous serial input, idle high
- char_ready  in  1  text buffer accepts character
- char_valid  out  1  decoded character available
- char_ascii  out  8  ASCII code
- char_color  out  4  colour attribute
- char_lang  out  1  language select
- frame_err  out  1  one-cycle pulse on bad stop bit (or bad parity)
- overrun  out  1  sticky: packet dropped because output was still held
- busy  out  1  high while a frame is being received or a packet is half assembled

## Operation
- rx passes through 2-flop synchroniser (reset value 1) before use.
- Bit engine states: IDLE, START, DATA, STOP. IDLE→START on synchronised falling edge; START checks rx at CLKS_PER_BIT/2: low→DATA, high→IDLE (glitch, no error). DATA samples 8 bits LSB-first, one every CLKS_PER_BIT from start mid-point. STOP samples at mid-bit: high→byte_done, low→frame_err pulse and byte discarded. Engine returns to IDLE immediately after the stop mid-sample.
- Packet FSM states: WAIT_HDR, WAIT_CHAR. Header byte = {3'b101, lang, color[3:0]}.
  - WAIT_HDR: byte with [7:5]==3'b101 latches lang/color, →WAIT_CHAR; any other byte ignored.
  - WAIT_CHAR: next good byte is ASCII (all 8 bits, no marker check) → packet complete, →WAIT_HDR.
  - frame_err in WAIT_CHAR → WAIT_HDR, partial packet dropped.
  - Timeout counter runs in WAIT_CHAR while bit engine IDLE; reaching TIMEOUT_CYCLES → WAIT_HDR silently.
- Output register: on packet complete with char_valid=0 (or char_valid & char_ready same cycle) load ascii/color/lang, set char_valid. If char_valid=1 and char_ready=0, new packet is dropped, overrun set, held data unchanged.
- char_valid & char_ready → char_valid cleared next cycle (if no simultaneous load).
- Outputs stable while char_valid=1.
- busy = (bit engine ≠ IDLE) | (packet FSM = WAIT_CHAR).

## Timing
- Reset values: char_valid 0, char_ascii 0, char_color 0, char_lang 0, frame_err 0, overrun 0, busy 0; both FSMs idle, counters 0.
- Reset asserted mid-frame aborts immediately; next frame needs a fresh falling edge after reset release.
- Synchroniser latency 2 cycles; char_valid rises 1 cycle after the ASCII byte's stop mid-sample.
- frame_err exactly one cycle wide.
- Back-to-back frames (stop bit followed directly by next start) received without loss.
- Handshake transfer occurs on a cycle where char_valid & char_ready are both 1.

## Configuration
- RX_PARITY_EN defined: each frame carries an even-parity bit between data bit 7 and stop; bit engine adds PARITY state; parity mismatch handled identically to bad stop bit (frame_err pulse, byte discarded, packet reset). Frame length 11 bits.
- Undefined: 8N1 frames, no parity state, 10-bit frames.

## Test plan
- CLKS_PER_BIT=16: send 0xA5 then 0x41 with char_ready=1 → one char_valid pulse, ascii 0x41, color 4'h5, lang 0; frame_err never asserted.
- Send 0x41 alone, then 0xB3, 0x7A → first byte ignored; output ascii 0x7A, color 4'h3, lang 1.
- Header 0xA0 followed by frame with stop bit forced low → frame_err one-cycle pulse, no char_valid; following 0xA2,0x30 decodes ascii 0x30, color 2.
- char_ready=0, send two full packets (0x41, then 0x42) → char_valid held with 0x41, overrun=1; raise ready → 0x41 accepted, char_valid drops, 0x42 never appears.
- Header 0xA1, idle > TIMEOUT_CYCLES, then 0x55 → nothing output (0x55 treated as non-header); busy low after timeout.
- Assert reset mid-data of an ASCII byte → all outputs 0 next cycle; subsequent clean packet 0xA7,0x5A decodes correctly; with RX_PARITY_EN, wrong parity on 0x5A → frame_err, no output.

Source files
------------

// File: rtl/uart_char_packet_rx_if.sv
// Character handshake bundle between the UART packet receiver and the text buffer.
// The receiver drives the decoded character; the text buffer returns char_ready.
interface uart_char_packet_rx_if;
   logic       char_valid;
   logic       char_ready;
   logic [7:0] char_ascii;
   logic [3:0] char_color;
   logic       char_lang;

   modport master (
      output char_valid,
      output char_ascii,
      output char_color,
      output char_lang,
      input  char_ready
   );

   modport slave (
      input  char_valid,
      input  char_ascii,
      input  char_color,
      input  char_lang,
      output char_ready
   );
endinterface

// File: rtl/uart_char_packet_rx.sv
// UART receiver that reassembles {header, ascii} character packets for the text buffer.
// Optional feature macro RX_PARITY_EN: adds an even-parity bit to every frame (8E1).
module uart_char_packet_rx #(
   parameter int CLKS_PER_BIT   = 868,
   parameter int TIMEOUT_CYCLES = 20 * 868
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx,
   uart_char_packet_rx_if.master  char_bus,
   output logic                   frame_err,
   output logic                   overrun,
   output logic                   busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [31:0]      TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ENG_IDLE   = 3'd0,
      ENG_START  = 3'd1,
      ENG_DATA   = 3'd2,
      ENG_PARITY = 3'd3,
      ENG_STOP   = 3'd4
   } eng_state_t;

   typedef enum logic {
      PKT_WAIT_HDR  = 1'b0,
      PKT_WAIT_CHAR = 1'b1
   } pkt_state_t;

   function automatic logic even_parity(input logic [7:0] data);
      return ^data;
   endfunction

   logic             rx_meta_r;
   logic             rx_sync_r;
   logic             rx_prev_r;
   eng_state_t       eng_state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [2:0]       bit_idx_r;
   logic [7:0]       shift_r;
   logic             par_ok_s;
   pkt_state_t       pkt_state_r;
   logic [31:0]      tmo_r;
   logic             hdr_lang_r;
   logic [3:0]       hdr_color_r;
   logic             valid_r;
   logic [7:0]       ascii_r;
   logic [3:0]       color_r;
   logic             lang_r;
   logic             frame_err_r;
   logic             overrun_r;
   logic             byte_good_s;
   logic             byte_bad_s;
   logic             pkt_done_s;
   logic             load_s;

`ifdef RX_PARITY_EN
   logic             par_ok_r;
   assign par_ok_s = par_ok_r;
`else
   assign par_ok_s = 1'b1;
`endif

   // Two-flop synchroniser plus previous-sample flop for falling-edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // Stop-bit mid-sample classifies the just-received byte as good or bad.
   always_comb begin
      byte_good_s = 1'b0;
      byte_bad_s  = 1'b0;
      if ((eng_state_r == ENG_STOP) && (cnt_r == BIT_LAST)) begin
         if (rx_sync_r && par_ok_s) begin
            byte_good_s = 1'b1;
         end else begin
            byte_bad_s = 1'b1;
         end
      end else begin
         byte_good_s = 1'b0;
         byte_bad_s  = 1'b0;
      end
   end

   assign pkt_done_s = byte_good_s && (pkt_state_r == PKT_WAIT_CHAR);
   assign load_s     = pkt_done_s && (!valid_r || char_bus.char_ready);

   // Bit engine: START waits half a bit, later states sample once per bit period.
   always_ff @(posedge clk) begin
      if (reset) begin
         eng_state_r <= ENG_IDLE;
         cnt_r       <= '0;
         bit_idx_r   <= 3'd0;
         shift_r     <= 8'h00;
`ifdef RX_PARITY_EN
         par_ok_r    <= 1'b1;
`endif
      end else begin
         case (eng_state_r)
            ENG_IDLE: begin
               cnt_r     <= '0;
               bit_idx_r <= 3'd0;
               if (rx_prev_r && !rx_sync_r) begin
                  eng_state_r <= ENG_START;
               end else begin
                  eng_state_r <= ENG_IDLE;
               end
            end
            ENG_START: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r       <= '0;
                  eng_state_r <= rx_sync_r ? ENG_IDLE : ENG_DATA;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ENG_DATA: begin
               if (cnt_r == BIT_LAST) begin
                  cnt_r   <= '0;
                  shift_r <= {rx_sync_r, shift_r[7:1]};
                  if (bit_idx_r == 3'd7) begin
`ifdef RX_PARITY_EN
                     eng_state_r <= ENG_PARITY;
`else
                     eng_state_r <= ENG_STOP;
`endif
                  end else begin
                     bit_idx_r <= bit_idx_r + 3'd1;
                  end
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ENG_PARITY: begin
`ifdef RX_PARITY_EN
               if (cnt_r == BIT_LAST) begin
                  cnt_r       <= '0;
                  par_ok_r    <= (rx_sync_r == even_parity(shift_r));
                  eng_state_r <= ENG_STOP;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
`else
               eng_state_r <= ENG_IDLE;
`endif
            end
            ENG_STOP: begin
               if (cnt_r == BIT_LAST) begin
                  cnt_r       <= '0;
                  eng_state_r <= ENG_IDLE;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               eng_state_r <= ENG_IDLE;
               cnt_r       <= '0;
            end
         endcase
      end
   end

   // Packet assembly: header latches attributes, next good byte completes the packet.
   always_ff @(posedge clk) begin
      if (reset) begin
         pkt_state_r <= PKT_WAIT_HDR;
         tmo_r       <= 32'd0;
         hdr_lang_r  <= 1'b0;
         hdr_color_r <= 4'h0;
      end else begin
         case (pkt_state_r)
            PKT_WAIT_HDR: begin
               tmo_r <= 32'd0;
               if (byte_good_s && (shift_r[7:5] == 3'b101)) begin
                  hdr_lang_r  <= shift_r[4];
                  hdr_color_r <= shift_r[3:0];
                  pkt_state_r <= PKT_WAIT_CHAR;
               end else begin
                  pkt_state_r <= PKT_WAIT_HDR;
               end
            end
            PKT_WAIT_CHAR: begin
               if (byte_good_s || byte_bad_s) begin
                  tmo_r       <= 32'd0;
                  pkt_state_r <= PKT_WAIT_HDR;
               end else if (eng_state_r == ENG_IDLE) begin
                  // Count only line-idle time; a frame in flight holds the timer.
                  if (tmo_r == TMO_LAST) begin
                     tmo_r       <= 32'd0;
                     pkt_state_r <= PKT_WAIT_HDR;
                  end else begin
                     tmo_r <= tmo_r + 32'd1;
                  end
               end else begin
                  tmo_r <= tmo_r;
               end
            end
            default: begin
               pkt_state_r <= PKT_WAIT_HDR;
               tmo_r       <= 32'd0;
            end
         endcase
      end
   end

   // Output holding register with sticky overrun when a held character blocks a new one.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r     <= 1'b0;
         ascii_r     <= 8'h00;
         color_r     <= 4'h0;
         lang_r      <= 1'b0;
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;
      end else begin
         frame_err_r <= byte_bad_s;
         if (load_s) begin
            valid_r <= 1'b1;
            ascii_r <= shift_r;
            color_r <= hdr_color_r;
            lang_r  <= hdr_lang_r;
         end else if (valid_r && char_bus.char_ready) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
         if (pkt_done_s && valid_r && !char_bus.char_ready) begin
            overrun_r <= 1'b1;
         end else begin
            overrun_r <= overrun_r;
         end
      end
   end

   assign char_bus.char_valid = valid_r;
   assign char_bus.char_ascii = ascii_r;
   assign char_bus.char_color = color_r;
   assign char_bus.char_lang  = lang_r;
   assign frame_err           = frame_err_r;
   assign overrun             = overrun_r;
   assign busy                = (eng_state_r != ENG_IDLE) || (pkt_state_r == PKT_WAIT_CHAR);

endmodule

// File: tb/tb_uart_char_packet_rx.sv
// Self-checking bench for uart_char_packet_rx: directed packet scenarios plus random
// byte streams, compared against a byte-level packet model kept in the bench.
module tb_uart_char_packet_rx;
   localparam int CPB = 16;
   localparam int TMO = 20 * CPB;
`ifdef RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic rx;
   logic frame_err;
   logic overrun;
   logic busy;

   uart_char_packet_rx_if bus ();

   always #5 clk = ~clk;

   uart_char_packet_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx        (rx),
      .char_bus  (bus),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   int checks   = 0;
   int failures = 0;
   int fe_cnt   = 0;
   int fe_exp   = 0;
   int fe_wide  = 0;
   logic fe_prev = 1'b0;
   logic [12:0] exp_q[$];
   logic [12:0] got_q[$];

   // Packet model state: pending header attributes and the held output character.
   bit          pending   = 1'b0;
   logic        m_lang    = 1'b0;
   logic [3:0]  m_color   = 4'h0;
   bit          mdl_valid = 1'b0;
   logic [12:0] mdl_hold  = 13'h0;
   bit          mdl_ovr   = 1'b0;

   // Monitor: record handshake transfers and frame_err pulses/width.
   always @(negedge clk) begin
      if (bus.char_valid === 1'b1 && bus.char_ready === 1'b1)
         got_q.push_back({bus.char_lang, bus.char_color, bus.char_ascii});
      if (frame_err === 1'b1) begin
         if (!fe_prev) fe_cnt++;
         else          fe_wide++;
      end
      fe_prev = (frame_err === 1'b1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mdl_complete(input logic [12:0] p);
      if (bus.char_ready) exp_q.push_back(p);
      else if (!mdl_valid) begin
         mdl_valid = 1'b1;
         mdl_hold  = p;
      end else mdl_ovr = 1'b1;
   endtask

   task automatic mdl_byte(input logic [7:0] b, input bit ok);
      if (!ok) begin
         fe_exp++;
         pending = 1'b0;
      end else if (!pending) begin
         if (b[7:5] == 3'b101) begin
            pending = 1'b1;
            m_lang  = b[4];
            m_color = b[3:0];
         end
      end else begin
         pending = 1'b0;
         mdl_complete({m_lang, m_color, b});
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par,
                             input int gap_bits);
      rx = 1'b0;
      step(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         step(CPB);
      end
      if (PAR) begin
         rx = (^b) ^ bad_par;
         step(CPB);
      end
      rx = ~bad_stop;
      step(CPB);
      rx = 1'b1;
      step(gap_bits * CPB);
      mdl_byte(b, !bad_stop && !(PAR && bad_par));
   endtask

   task automatic compare(input string tag);
      int n;
      step(4);
      check({tag, "_count"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) check({tag, "_char"}, got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
      check({tag, "_fe_pulses"}, fe_cnt, fe_exp);
      check({tag, "_fe_width"}, fe_wide, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, bus.char_valid, 0);
      check({tag, "_ascii"}, bus.char_ascii, 0);
      check({tag, "_color"}, bus.char_color, 0);
      check({tag, "_lang"},  bus.char_lang, 0);
      check({tag, "_ferr"},  frame_err, 0);
      check({tag, "_ovr"},   overrun, 0);
      check({tag, "_busy"},  busy, 0);
   endtask

   initial begin
      logic [7:0] v;
      bit         bs, bp;
      int         gap;

      reset = 1'b1;
      rx = 1'b1;
      bus.char_ready = 1'b1;
      step(3);
      check_all_zero("reset");
      reset = 1'b0;
      step(4);

      // Header then ASCII, back to back.
      send_frame(8'hA5, 1'b0, 1'b0, 0);
      send_frame(8'h41, 1'b0, 1'b0, 2);
      compare("basic");

      // Non-header byte ignored before a real packet.
      send_frame(8'h41, 1'b0, 1'b0, 1);
      send_frame(8'hB3, 1'b0, 1'b0, 1);
      send_frame(8'h7A, 1'b0, 1'b0, 2);
      compare("skip_nonhdr");

      // Bad stop bit drops the partial packet.
      send_frame(8'hA0, 1'b0, 1'b0, 1);
      send_frame(8'h41, 1'b1, 1'b0, 1);
      send_frame(8'hA2, 1'b0, 1'b0, 0);
      send_frame(8'h30, 1'b0, 1'b0, 2);
      compare("bad_stop");

      // Output held while not ready: second packet lost, overrun sticks.
      bus.char_ready = 1'b0;
      send_frame(8'hA4, 1'b0, 1'b0, 1);
      send_frame(8'h41, 1'b0, 1'b0, 1);
      send_frame(8'hA4, 1'b0, 1'b0, 1);
      send_frame(8'h42, 1'b0, 1'b0, 1);
      check("hold_valid", bus.char_valid, mdl_valid);
      check("hold_data", {bus.char_lang, bus.char_color, bus.char_ascii}, mdl_hold);
      check("hold_ovr", overrun, mdl_ovr);
      bus.char_ready = 1'b1;
      if (mdl_valid) begin
         exp_q.push_back(mdl_hold);
         mdl_valid = 1'b0;
      end
      step(1);
      check("release_valid", bus.char_valid, 0);
      check("ovr_sticky", overrun, mdl_ovr);
      compare("overrun");

      // Header then long silence: packet FSM times out.
      send_frame(8'hA1, 1'b0, 1'b0, 0);
      check("tmo_busy_wait", busy, 1);
      step(TMO + CPB);
      pending = 1'b0;
      check("tmo_busy_after", busy, 0);
      send_frame(8'h55, 1'b0, 1'b0, 2);
      check("tmo_busy_end", busy, 0);
      compare("timeout");

      // Reset in the middle of the ASCII byte's data bits.
      send_frame(8'hA7, 1'b0, 1'b0, 1);
      v = 8'h5A;
      rx = 1'b0;
      step(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = v[i];
         step(CPB);
      end
      step(CPB / 2);
      reset = 1'b1;
      rx = 1'b1;
      step(1);
      check_all_zero("midreset");
      reset = 1'b0;
      pending = 1'b0;
      mdl_valid = 1'b0;
      mdl_ovr = 1'b0;
      step(4);
      send_frame(8'hA7, 1'b0, 1'b0, 0);
      send_frame(8'h5A, 1'b0, 1'b0, 2);
      compare("after_reset");
      send_frame(8'hA7, 1'b0, 1'b0, 1);
      send_frame(8'h5A, !PAR, PAR, 2);
      compare("bad_frame");
      check("final_ovr", overrun, mdl_ovr);

      // Random byte stream with occasional framing/parity faults.
      for (int k = 0; k < 30; k++) begin
         if ($urandom_range(0, 1) == 1) v = {3'b101, 5'($urandom)};
         else                           v = 8'($urandom);
         bs  = ($urandom_range(0, 7) == 0);
         bp  = ($urandom_range(0, 7) == 0);
         gap = $urandom_range(0, 2);
         if (bs && gap == 0) gap = 1;
         send_frame(v, bs, bp, gap);
      end
      step(2 * CPB);
      compare("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
